// File: rtl/muldiv_unit.sv
// Iterative 16-bit multiply/divide unit: 16 shift-add / restoring-divide steps, a finalize cycle, then write-back.
// Optional signed arithmetic via `MULDIV_SIGNED_EN (op[2] selects signed); without it every op is unsigned.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [3:0]  in_rd,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        flush,
  output logic        busy,
  output logic [3:0]  busy_rd,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [3:0]  wb_addr,
  output logic [15:0] wb_data
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_reg;
  logic [1:0]  op_reg;
  logic [3:0]  rd_reg;
  logic [15:0] opnd_reg;
  logic [31:0] acc_reg;
  logic [4:0]  cnt_reg;
  logic        div0_reg;
  logic        wb_valid_reg;
  logic [3:0]  wb_addr_reg;
  logic [15:0] wb_data_reg;

  logic [15:0] mag_a;
  logic [15:0] mag_b;

`ifdef MULDIV_SIGNED_EN
  logic sign_a;
  logic sign_b;
  logic neg_a_reg;
  logic neg_b_reg;

  assign sign_a = in_op[2] & in_a[15];
  assign sign_b = in_op[2] & in_b[15];
  assign mag_a  = sign_a ? (16'd0 - in_a) : in_a;
  assign mag_b  = sign_b ? (16'd0 - in_b) : in_b;
`else
  logic unused_op2;

  assign unused_op2 = in_op[2];
  assign mag_a      = in_a;
  assign mag_b      = in_b;
`endif

  // One iteration: MUL shifts the product right, adding the multiplicand when the low bit is set;
  // DIV shifts {remainder, quotient} left and keeps the trial subtraction when it does not borrow.
  logic [16:0] add_sum;
  logic [16:0] rem_shift;
  logic [17:0] trial;
  logic [31:0] acc_step;

  always_comb begin
    add_sum   = {1'b0, acc_reg[31:16]} + (acc_reg[0] ? {1'b0, opnd_reg} : 17'd0);
    rem_shift = acc_reg[31:15];
    trial     = {1'b0, rem_shift} - {2'b00, opnd_reg};
    acc_step  = {add_sum, acc_reg[15:1]};
    if (op_reg[1]) begin
      if (!trial[17]) begin
        acc_step = {trial[15:0], acc_reg[14:0], 1'b1};
      end else begin
        acc_step = {rem_shift[15:0], acc_reg[14:0], 1'b0};
      end
    end
  end

  logic [31:0] prod_fix;
  logic [15:0] quo_fix;
  logic [15:0] rem_fix;
  logic [15:0] result;

  always_comb begin
`ifdef MULDIV_SIGNED_EN
    prod_fix = (neg_a_reg ^ neg_b_reg) ? (32'd0 - acc_reg) : acc_reg;
    quo_fix  = (neg_a_reg ^ neg_b_reg) ? (16'd0 - acc_reg[15:0]) : acc_reg[15:0];
    rem_fix  = neg_a_reg ? (16'd0 - acc_reg[31:16]) : acc_reg[31:16];
`else
    prod_fix = acc_reg;
    quo_fix  = acc_reg[15:0];
    rem_fix  = acc_reg[31:16];
`endif
    case (op_reg)
      2'b00:   result = prod_fix[15:0];
      2'b01:   result = prod_fix[31:16];
      2'b10:   result = div0_reg ? 16'hFFFF : quo_fix;
      default: result = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      op_reg       <= 2'b00;
      rd_reg       <= 4'd0;
      opnd_reg     <= 16'd0;
      acc_reg      <= 32'd0;
      cnt_reg      <= 5'd0;
      div0_reg     <= 1'b0;
      wb_valid_reg <= 1'b0;
      wb_addr_reg  <= 4'd0;
      wb_data_reg  <= 16'd0;
`ifdef MULDIV_SIGNED_EN
      neg_a_reg    <= 1'b0;
      neg_b_reg    <= 1'b0;
`endif
    end else if (flush) begin
      state_reg    <= IDLE;
      wb_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            op_reg    <= in_op[1:0];
            rd_reg    <= in_rd;
            // Multiplicand for MUL/MULH, divisor for DIV/REM.
            opnd_reg  <= in_op[1] ? mag_b : mag_a;
            acc_reg   <= {16'd0, in_op[1] ? mag_a : mag_b};
            div0_reg  <= (in_b == 16'd0);
            cnt_reg   <= 5'd16;
            state_reg <= CALC;
`ifdef MULDIV_SIGNED_EN
            neg_a_reg <= sign_a;
            neg_b_reg <= sign_b;
`endif
          end
        end
        CALC: begin
          if (cnt_reg != 5'd0) begin
            acc_reg <= acc_step;
            cnt_reg <= cnt_reg - 5'd1;
          end else begin
            wb_data_reg  <= result;
            wb_addr_reg  <= rd_reg;
            wb_valid_reg <= 1'b1;
            state_reg    <= DONE;
          end
        end
        DONE: begin
          if (wb_ready) begin
            wb_valid_reg <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready = (state_reg == IDLE) && !rst;
  assign busy     = (state_reg != IDLE);
  assign busy_rd  = rd_reg;
  assign wb_valid = wb_valid_reg;
  assign wb_addr  = wb_addr_reg;
  assign wb_data  = wb_data_reg;

endmodule
